// File: rtl/ultrasonic_echo_emulator_if.sv
// Trigger/echo pin bundle between the ranging block (master) and the
// ultrasonic sensor emulator (slave).
interface ultrasonic_echo_emulator_if;
  localparam int unsigned DIST_W = 10;
  localparam int unsigned CNT_W  = 16;

  logic              trig;
  logic [DIST_W-1:0] distance_cm;
  logic              echo;
  logic              busy;
  logic              trig_err;
  logic              meas_done;
  logic              out_of_range;
  logic [CNT_W-1:0]  meas_cnt;

  modport master (
    output trig, distance_cm,
    input  echo, busy, trig_err, meas_done, out_of_range, meas_cnt
  );

  modport slave (
    input  trig, distance_cm,
    output echo, busy, trig_err, meas_done, out_of_range, meas_cnt
  );
endinterface

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04 responder: answers a valid trig pulse with an echo pulse whose
// width encodes distance_cm, using the real sensor's timing envelope.
module ultrasonic_echo_emulator #(
  parameter int unsigned TRIG_MIN_CYC = 1000,
  parameter int unsigned BURST_CYC    = 20000,
  parameter int unsigned CYC_PER_CM   = 5800,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_CYC  = 3800000,
  parameter int unsigned HOLDOFF_CYC  = 6000000
) (
  input logic                       clk,
  input logic                       rst,
  ultrasonic_echo_emulator_if.slave bus
);

  localparam int unsigned CW = 32;

  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

  state_t          state, state_nx;
  logic            trig_s1, ts, ts_d;
  logic            ts_rise, ts_fall;
  logic [CW-1:0]   hcnt, hcnt_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [CW-1:0]   width, width_nx;
  logic            echo_nx, trig_err_nx, meas_done_nx, oor_nx, busy_nx;
  logic [15:0]     meas_cnt_nx;

  assign ts_rise = ts & ~ts_d;
  assign ts_fall = ~ts & ts_d;

  // Two-flop synchronizer on trig plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_s1 <= 1'b0;
      ts      <= 1'b0;
      ts_d    <= 1'b0;
    end else begin
      trig_s1 <= bus.trig;
      ts      <= trig_s1;
      ts_d    <= ts;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      hcnt             <= '0;
      cnt              <= '0;
      width            <= '0;
      bus.echo         <= 1'b0;
      bus.busy         <= 1'b0;
      bus.trig_err     <= 1'b0;
      bus.meas_done    <= 1'b0;
      bus.out_of_range <= 1'b0;
      bus.meas_cnt     <= '0;
    end else begin
      state            <= state_nx;
      hcnt             <= hcnt_nx;
      cnt              <= cnt_nx;
      width            <= width_nx;
      bus.echo         <= echo_nx;
      bus.busy         <= busy_nx;
      bus.trig_err     <= trig_err_nx;
      bus.meas_done    <= meas_done_nx;
      bus.out_of_range <= oor_nx;
      bus.meas_cnt     <= meas_cnt_nx;
    end
  end

  // Next-state and next-output decode; echo is high on every ECHO-state cycle.
  always_comb begin
    state_nx     = state;
    hcnt_nx      = hcnt;
    cnt_nx       = cnt;
    width_nx     = width;
    echo_nx      = 1'b0;
    trig_err_nx  = 1'b0;
    meas_done_nx = 1'b0;
    oor_nx       = bus.out_of_range;
    meas_cnt_nx  = bus.meas_cnt;
    unique case (state)
      IDLE: begin
        if (ts_rise) begin
          state_nx = TRIG_HI;
          hcnt_nx  = CW'(1);
        end
      end
      TRIG_HI: begin
        if (ts_fall) begin
          if (hcnt >= TRIG_MIN_CYC) begin
            state_nx = BURST;
            cnt_nx   = '0;
            if (bus.distance_cm == '0 || CW'(bus.distance_cm) > MAX_CM) begin
              width_nx = TIMEOUT_CYC;
              oor_nx   = 1'b1;
            end else begin
              width_nx = CW'(bus.distance_cm) * CYC_PER_CM;
              oor_nx   = 1'b0;
            end
          end else begin
            state_nx    = IDLE;
            trig_err_nx = 1'b1;
          end
        end else if (hcnt < TRIG_MIN_CYC) begin
          hcnt_nx = hcnt + CW'(1);
        end
      end
      BURST: begin
        if (cnt == BURST_CYC - 1) begin
          state_nx = ECHO;
          cnt_nx   = '0;
          echo_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ECHO: begin
        if (cnt == width - CW'(1)) begin
          state_nx     = HOLDOFF;
          cnt_nx       = '0;
          meas_done_nx = 1'b1;
          meas_cnt_nx  = bus.meas_cnt + 16'd1;
        end else begin
          cnt_nx  = cnt + CW'(1);
          echo_nx = 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLDOFF_CYC - 1) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule
